// File: rtl/wb_arbiter_pkg.sv
// Purpose : shared widths and writeback packet type for the PRF writeback arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package wb_arbiter_pkg;
  localparam int XLEN      = 32;
  localparam int PREGS     = 64;
  localparam int ROB_DEPTH = 32;
  localparam int WB_N_SRC  = 4;

  typedef logic [$clog2(PREGS)-1:0]     preg_tag_t;
  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;

  typedef struct packed {
    preg_tag_t         tag;
    logic [XLEN-1:0]   data;
    rob_idx_t          rob_idx;
  } wb_pkt_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Purpose : bundle of FU result handshakes and the two PRF write ports.
// Latency : n/a (wires only).
// Backpressure: src_ready per source; write ports have no backpressure.
// Ports   : master = result producers / PRF observer, slave = arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int N_SRC = WB_N_SRC
) ();
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_ready;
  wb_pkt_t [N_SRC-1:0] src_pkt;

  logic                wen0;
  logic                wen1;
  preg_tag_t           wtag0;
  preg_tag_t           wtag1;
  logic [XLEN-1:0]     wdata0;
  logic [XLEN-1:0]     wdata1;
  rob_idx_t            wrob0;
  rob_idx_t            wrob1;

  modport master (
    output src_valid, src_pkt,
    input  src_ready,
    input  wen0, wen1, wtag0, wtag1, wdata0, wdata1, wrob0, wrob1
  );

  modport slave (
    input  src_valid, src_pkt,
    output src_ready,
    output wen0, wen1, wtag0, wtag1, wdata0, wdata1, wrob0, wrob1
  );
endinterface

// File: rtl/wb_pick2.sv
// Purpose : rotating-priority picker, up to two of N occupied slots per cycle.
// Latency : combinational (0 cycles).
// Backpressure: none; caller masks occ to suppress grants.
// Ports   : occ/rr_ptr in; gnt0_v/gnt0_idx, gnt1_v/gnt1_idx, rr_next out.
module wb_pick2
  import wb_arbiter_pkg::*;
#(
  parameter  int N_SRC = WB_N_SRC,
  localparam int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] occ,
  input  logic [IW-1:0]    rr_ptr,
  output logic             gnt0_v,
  output logic [IW-1:0]    gnt0_idx,
  output logic             gnt1_v,
  output logic [IW-1:0]    gnt1_idx,
  output logic [IW-1:0]    rr_next
);

  // (a + n) mod N_SRC, valid for a < N_SRC and n <= N_SRC.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int n);
    int s;
    s = int'(a) + n;
    if (s >= N_SRC) s = s - N_SRC;
    return IW'(s);
  endfunction

  logic [IW-1:0] idx;

  always_comb begin
    gnt0_v   = 1'b0;
    gnt0_idx = '0;
    gnt1_v   = 1'b0;
    gnt1_idx = '0;
    rr_next  = rr_ptr;
    idx      = '0;
    // Scan from rr_ptr: first occupied slot wins port 0, second wins port 1.
    for (int i = 0; i < N_SRC; i++) begin
      idx = wrap_add(rr_ptr, i);
      if (occ[idx]) begin
        if (!gnt0_v) begin
          gnt0_v   = 1'b1;
          gnt0_idx = idx;
        end else if (!gnt1_v) begin
          gnt1_v   = 1'b1;
          gnt1_idx = idx;
        end
      end
    end
    // Next scan starts just past the last slot granted this cycle.
    if (gnt1_v)      rr_next = wrap_add(gnt1_idx, 1);
    else if (gnt0_v) rr_next = wrap_add(gnt0_idx, 1);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose : buffers one result per FU source and drives two registered PRF write ports.
// Latency : 2 cycles minimum from source handshake to wen (slot, then output register).
// Backpressure: src_ready = !flush && (slot empty || slot granted); no valid->ready path.
// Ports   : clk, reset_n (async, active-low), flush (sync); bus = wb_arbiter_if.slave.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN      = wb_arbiter_pkg::XLEN,
  parameter int PREGS     = wb_arbiter_pkg::PREGS,
  parameter int ROB_DEPTH = wb_arbiter_pkg::ROB_DEPTH,
  parameter int N_SRC     = WB_N_SRC
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  wb_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_SRC);

  // The packet layout is fixed by the package; reject mismatched overrides.
  if (N_SRC < 2 || N_SRC > 8) begin : g_bad_nsrc
    $error("wb_arbiter: N_SRC must be in 2..8");
  end
  if (XLEN != wb_arbiter_pkg::XLEN || $clog2(PREGS) != $bits(preg_tag_t) ||
      $clog2(ROB_DEPTH) != $bits(rob_idx_t)) begin : g_bad_width
    $error("wb_arbiter: width parameters disagree with wb_arbiter_pkg");
  end

  logic [N_SRC-1:0] slot_v;
  wb_pkt_t          slot_pkt [N_SRC];
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    rr_next;

  logic [N_SRC-1:0] occ;
  logic [N_SRC-1:0] grant;
  logic [N_SRC-1:0] accept;
  logic             gnt0_v, gnt1_v;
  logic [IW-1:0]    gnt0_idx, gnt1_idx;

  logic             wen0_q, wen1_q;
  wb_pkt_t          out0_q, out1_q;

  // Flush masks occupancy so nothing is granted in the flush cycle.
  assign occ = flush ? '0 : slot_v;

  wb_pick2 #(.N_SRC(N_SRC)) u_pick (
    .occ      (occ),
    .rr_ptr   (rr_ptr),
    .gnt0_v   (gnt0_v),
    .gnt0_idx (gnt0_idx),
    .gnt1_v   (gnt1_v),
    .gnt1_idx (gnt1_idx),
    .rr_next  (rr_next)
  );

  always_comb begin
    grant = '0;
    if (gnt0_v) grant[gnt0_idx] = 1'b1;
    if (gnt1_v) grant[gnt1_idx] = 1'b1;
  end

  // A slot being drained this cycle can be refilled at the same edge.
  assign bus.src_ready = flush ? '0 : (~slot_v | grant);
  assign accept        = bus.src_valid & bus.src_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_v <= '0;
      for (int i = 0; i < N_SRC; i++) slot_pkt[i] <= '0;
      rr_ptr <= '0;
      wen0_q <= 1'b0;
      wen1_q <= 1'b0;
      out0_q <= '0;
      out1_q <= '0;
    end else if (flush) begin
      slot_v <= '0;
      rr_ptr <= '0;
      wen0_q <= 1'b0;
      wen1_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (accept[i]) begin
          slot_v[i]   <= 1'b1;
          slot_pkt[i] <= bus.src_pkt[i];
        end else if (grant[i]) begin
          slot_v[i]   <= 1'b0;
        end
      end
      rr_ptr <= rr_next;
      wen0_q <= gnt0_v;
      wen1_q <= gnt1_v;
      // Payload holds its last value while wen is low.
      if (gnt0_v) out0_q <= slot_pkt[gnt0_idx];
      if (gnt1_v) out1_q <= slot_pkt[gnt1_idx];
    end
  end

  assign bus.wen0   = wen0_q;
  assign bus.wtag0  = out0_q.tag;
  assign bus.wdata0 = out0_q.data;
  assign bus.wrob0  = out0_q.rob_idx;
  assign bus.wen1   = wen1_q;
  assign bus.wtag1  = out1_q.tag;
  assign bus.wdata1 = out1_q.data;
  assign bus.wrob1  = out1_q.rob_idx;

  // Two occupied slots carrying the same destination tag means rename broke.
  logic dup_tag;
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < N_SRC; i++)
      for (int j = i + 1; j < N_SRC; j++)
        if (slot_v[i] && slot_v[j] && slot_pkt[i].tag == slot_pkt[j].tag) dup_tag = 1'b1;
  end

  a_no_dup_tag: assert property (@(posedge clk) disable iff (!reset_n) !dup_tag)
    else $error("wb_arbiter: duplicate destination tag in occupied slots");

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  always #5 clk = ~clk;

  wb_arbiter_if #(.N_SRC(4)) bus ();

  wb_arbiter #(.N_SRC(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.src_valid = '0;
    bus.src_pkt   = '0;
  endtask

  task automatic set_src(input int i, input preg_tag_t t, input logic [31:0] d, input rob_idx_t r);
    bus.src_valid[i] = 1'b1;
    bus.src_pkt[i]   = '{tag: t, data: d, rob_idx: r};
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    idle_inputs();
    repeat (2) tick();
    n_cmp++; if (bus.wen0 !== 1'b0) begin n_bad++; $display("FAIL reset_wen0: got %b want 0", bus.wen0); end
    n_cmp++; if (bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL reset_wen1: got %b want 0", bus.wen1); end
    n_cmp++; if ({bus.wtag0, bus.wdata0, bus.wrob0, bus.wtag1, bus.wdata1, bus.wrob1} !== '0) begin
      n_bad++; $display("FAIL reset_payload: got tag0=%0d data0=%h rob0=%0d tag1=%0d data1=%h rob1=%0d want all 0",
                        bus.wtag0, bus.wdata0, bus.wrob0, bus.wtag1, bus.wdata1, bus.wrob1);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.src_ready !== 4'b1111) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", bus.src_ready); end
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_reset_midrun();
    idle_inputs();
    tick();
    set_src(0, 6'd1, 32'h1111_0000, 5'd1);
    set_src(2, 6'd2, 32'h2222_0000, 5'd2);
    tick();
    // Refill both slots in the same cycle they are granted.
    set_src(0, 6'd3, 32'h3333_0000, 5'd3);
    set_src(2, 6'd4, 32'h4444_0000, 5'd4);
    tick();
    idle_inputs();
    n_cmp++; if (bus.wen0 !== 1'b1 || bus.wtag0 !== 6'd1) begin n_bad++; $display("FAIL midrun_pre_p0: got wen0=%b tag0=%0d want 1/1", bus.wen0, bus.wtag0); end
    n_cmp++; if (bus.wen1 !== 1'b1 || bus.wtag1 !== 6'd2) begin n_bad++; $display("FAIL midrun_pre_p1: got wen1=%b tag1=%0d want 1/2", bus.wen1, bus.wtag1); end
    n_cmp++; if (dut.slot_v !== 4'b0101) begin n_bad++; $display("FAIL midrun_pre_slots: got %b want 0101", dut.slot_v); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.wen0 !== 1'b0 || bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL midrun_wen: got wen0=%b wen1=%b want 0/0", bus.wen0, bus.wen1); end
    n_cmp++; if (dut.slot_v !== 4'b0000) begin n_bad++; $display("FAIL midrun_slots: got %b want 0000", dut.slot_v); end
    tick();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.src_ready !== 4'b1111) begin n_bad++; $display("FAIL midrun_ready: got %b want 1111", bus.src_ready); end
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL midrun_rr: got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_single();
    idle_inputs();
    set_src(1, 6'd5, 32'hDEADBEEF, 5'd3);
    tick();
    idle_inputs();
    n_cmp++; if (bus.wen0 !== 1'b0) begin n_bad++; $display("FAIL single_c1_wen0: got %b want 0", bus.wen0); end
    tick();
    n_cmp++; if (bus.wen0 !== 1'b1) begin n_bad++; $display("FAIL single_wen0: got %b want 1", bus.wen0); end
    n_cmp++; if (bus.wtag0 !== 6'd5) begin n_bad++; $display("FAIL single_tag0: got %0d want 5", bus.wtag0); end
    n_cmp++; if (bus.wdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data0: got %h want deadbeef", bus.wdata0); end
    n_cmp++; if (bus.wrob0 !== 5'd3) begin n_bad++; $display("FAIL single_rob0: got %0d want 3", bus.wrob0); end
    n_cmp++; if (bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL single_wen1: got %b want 0", bus.wen1); end
    tick();
    n_cmp++; if (bus.wen0 !== 1'b0 || bus.wtag0 !== 6'd5) begin n_bad++; $display("FAIL single_hold: got wen0=%b tag0=%0d want 0/5", bus.wen0, bus.wtag0); end
  endtask

  task automatic test_all_four();
    do_flush();
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL all4_rr_start: got %0d want 0", dut.rr_ptr); end
    for (int i = 0; i < 4; i++) set_src(i, preg_tag_t'(10 + i), 32'(100 + i), rob_idx_t'(i));
    tick();
    idle_inputs();
    tick();
    n_cmp++; if (bus.wen0 !== 1'b1 || bus.wtag0 !== 6'd10 || bus.wdata0 !== 32'd100) begin
      n_bad++; $display("FAIL all4_c1_p0: got wen0=%b tag0=%0d data0=%0d want 1/10/100", bus.wen0, bus.wtag0, bus.wdata0);
    end
    n_cmp++; if (bus.wen1 !== 1'b1 || bus.wtag1 !== 6'd11 || bus.wrob1 !== 5'd1) begin
      n_bad++; $display("FAIL all4_c1_p1: got wen1=%b tag1=%0d rob1=%0d want 1/11/1", bus.wen1, bus.wtag1, bus.wrob1);
    end
    tick();
    n_cmp++; if (bus.wen0 !== 1'b1 || bus.wtag0 !== 6'd12) begin n_bad++; $display("FAIL all4_c2_p0: got wen0=%b tag0=%0d want 1/12", bus.wen0, bus.wtag0); end
    n_cmp++; if (bus.wen1 !== 1'b1 || bus.wtag1 !== 6'd13) begin n_bad++; $display("FAIL all4_c2_p1: got wen1=%b tag1=%0d want 1/13", bus.wen1, bus.wtag1); end
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL all4_rr_end: got %0d want 0", dut.rr_ptr); end
    tick();
    n_cmp++; if (bus.wen0 !== 1'b0 || bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL all4_drained: got wen0=%b wen1=%b want 0/0", bus.wen0, bus.wen1); end
  endtask

  task automatic test_streaming();
    int exp_tag;
    exp_tag = 20;
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c < 8) begin
        set_src(0, preg_tag_t'(20 + c), 32'(c), rob_idx_t'(c));
        n_cmp++; if (bus.src_ready[0] !== 1'b1) begin n_bad++; $display("FAIL stream_ready c=%0d: got %b want 1", c, bus.src_ready[0]); end
      end
      tick();
      if (bus.wen0 === 1'b1) begin
        n_cmp++; if (int'(bus.wtag0) != exp_tag) begin n_bad++; $display("FAIL stream_tag c=%0d: got %0d want %0d", c, bus.wtag0, exp_tag); end
        exp_tag++;
      end
      n_cmp++; if (bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL stream_wen1 c=%0d: got %b want 0", c, bus.wen1); end
    end
    idle_inputs();
    n_cmp++; if (exp_tag != 28) begin n_bad++; $display("FAIL stream_count: got %0d writes want 8", exp_tag - 20); end
  endtask

  task automatic test_fairness();
    int cnt [3];
    int miss [3];
    int gcount [3];
    logic [3:0] rdy;
    logic [3:0] got;
    do_flush();
    for (int s = 0; s < 3; s++) begin cnt[s] = 0; miss[s] = 0; gcount[s] = 0; end
    for (int cyc = 0; cyc <= 6; cyc++) begin
      for (int s = 0; s < 3; s++) set_src(s, preg_tag_t'(s * 16 + cnt[s]), 32'(s), rob_idx_t'(s));
      rdy = bus.src_ready;
      tick();
      for (int s = 0; s < 3; s++) if (rdy[s]) cnt[s]++;
      if (cyc >= 1) begin
        got = '0;
        if (bus.wen0 === 1'b1) got[bus.wtag0[5:4]] = 1'b1;
        if (bus.wen1 === 1'b1) got[bus.wtag1[5:4]] = 1'b1;
        for (int s = 0; s < 3; s++) begin
          if (got[s]) begin gcount[s]++; miss[s] = 0; end
          else miss[s]++;
          n_cmp++; if (miss[s] > 1) begin n_bad++; $display("FAIL fair_wait src=%0d cyc=%0d: got %0d idle cycles want <=1", s, cyc, miss[s]); end
        end
      end
    end
    idle_inputs();
    for (int s = 0; s < 3; s++) begin
      n_cmp++; if (gcount[s] != 4) begin n_bad++; $display("FAIL fair_count src=%0d: got %0d grants want 4", s, gcount[s]); end
    end
    repeat (3) tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    set_src(0, 6'd50, 32'h5050, 5'd10);
    set_src(3, 6'd51, 32'h5151, 5'd11);
    tick();
    idle_inputs();
    set_src(1, 6'd52, 32'h5252, 5'd12);
    flush = 1'b1;
    #1;
    n_cmp++; if (bus.src_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready: got %b want 0000", bus.src_ready); end
    tick();
    flush = 1'b0;
    idle_inputs();
    n_cmp++; if (bus.wen0 !== 1'b0 || bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL flush_wen: got wen0=%b wen1=%b want 0/0", bus.wen0, bus.wen1); end
    n_cmp++; if (dut.slot_v !== 4'b0000) begin n_bad++; $display("FAIL flush_slots: got %b want 0000", dut.slot_v); end
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL flush_rr: got %0d want 0", dut.rr_ptr); end
    tick();
    n_cmp++; if (bus.wen0 !== 1'b0 || bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL flush_stale: got wen0=%b wen1=%b want 0/0", bus.wen0, bus.wen1); end
    set_src(2, 6'd53, 32'hCAFE_F00D, 5'd13);
    tick();
    idle_inputs();
    n_cmp++; if (bus.wen0 !== 1'b0) begin n_bad++; $display("FAIL postflush_c1: got wen0=%b want 0", bus.wen0); end
    tick();
    n_cmp++; if (bus.wen0 !== 1'b1 || bus.wtag0 !== 6'd53 || bus.wdata0 !== 32'hCAFE_F00D || bus.wrob0 !== 5'd13) begin
      n_bad++; $display("FAIL postflush_write: got wen0=%b tag0=%0d data0=%h rob0=%0d want 1/53/cafef00d/13",
                        bus.wen0, bus.wtag0, bus.wdata0, bus.wrob0);
    end
    n_cmp++; if (bus.wen1 !== 1'b0) begin n_bad++; $display("FAIL postflush_wen1: got %b want 0", bus.wen1); end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_single();
    test_all_four();
    test_streaming();
    test_fairness();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter sitting directly upstream of the physical register file's two write ports.
- Collects results from N_SRC functional-unit result ports (default: ALU0, ALU1, MUL, LSU), buffers one result per source, and grants up to two per cycle with rotating priority.
- Drives registered PRF write ports 0/1, which double as the wakeup broadcast and ROB-completion bus.

Parameters:
- XLEN, core_pkg::XLEN (32), datapath width.
- PREGS, core_pkg::PREGS (64), physical register count; tag width is $clog2(PREGS).
- ROB_DEPTH, core_pkg::ROB_DEPTH (32), ROB entries; rob index width is $clog2(ROB_DEPTH).
- N_SRC, 4, number of result sources; legal range 2..8.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; synchronous, active-high.
- src_valid  in  N_SRC  source i presents a result.
- src_ready  out  N_SRC  source i result accepted this cycle when valid&ready.
- src_pkt  in  N_SRC x wb_pkt_t  {tag, data, rob_idx} per source.
- wen0/wen1  out  1  PRF write enables.
- wtag0/wtag1  out  preg_tag_t  PRF write tags.
- wdata0/wdata1  out  XLEN  PRF write data.
- wrob0/wrob1  out  rob_idx_t  ROB completion index, qualified by wen0/wen1.

Behaviour:
- Reset (reset_n=0, asynchronous): all holding slots empty, rr_ptr=0, wen0=wen1=0, and wtag/wdata/wrob=0 on both ports.
- Holding slot per source: slot_v[i] plus a stored wb_pkt_t.
- src_ready[i] = !flush && (!slot_v[i] || grant[i]). src_ready depends only on slot state, grant and flush, never on src_valid, so there is no combinational valid→ready path.
- Accept: src_valid[i] && src_ready[i] loads the slot at the clock edge. Simultaneous grant and accept on the same source is legal, giving full throughput of one result per cycle per source.
- Arbitration (combinational, occupied slots only):
  - Scan indices rr_ptr, rr_ptr+1, … mod N_SRC.
  - The first occupied slot goes to port 0; the second goes to port 1.
  - Granted slots clear at the edge unless refilled by a same-cycle accept.
- rr_ptr update: if any grant, rr_ptr ← (index of last granted slot + 1) mod N_SRC; otherwise rr_ptr is unchanged.
- Output stage: registered. wen0/wtag0/wdata0/wrob0 ← port-0 grant; same for port 1. wen deasserts when there is no grant; payload holds its last value when wen=0.
- Latency: a source handshake in cycle C puts the slot in contention in C+1. If granted in C+1, wen is high in C+2. Minimum latency is 2 cycles.
- Fairness: an occupied slot is granted within ceil(N_SRC/2)-1 cycles of becoming eligible (1 cycle for N_SRC=4).
- Single occupant: it always takes port 0 and wen1 stays 0. Port 1 is never used without port 0.
- flush:
  - In the flush cycle, all src_ready=0 and no grants are issued.
  - At the edge, all slots are cleared, rr_ptr=0, and wen0=wen1=0.
  - An output already registered before the flush edge still appears in the flush cycle; flushing it is the ROB's responsibility.
- Reset mid-operation: everything returns to reset values immediately. In-flight results are discarded.
- Duplicate tags: the same tag in two occupied slots is a rename error. A simulation-only assertion flags it. The hardware issues both anyway in port order, and the PRF gives port 0 priority.

Decomposition:
- core_pkg gains:
  - wb_pkt_t struct {preg_tag_t tag; logic [XLEN-1:0] data; rob_idx_t rob_idx}.
  - rob_idx_t.
  - ROB_DEPTH.
  - WB_N_SRC=4.
- preg_tag_t already exists in core_pkg.
- Sub-module wb_pick2: purely combinational rotating two-of-N picker.
  - Inputs: occupancy vector and rr_ptr.
  - Outputs: gnt0_v, gnt0_idx, gnt1_v, gnt1_idx, and the next rr_ptr.
- wb_arbiter holds the slots, rr_ptr and output registers.

Test Plan:
- Reset check: reset_n=0 mid-run with slots 0 and 2 full → wen0=wen1=0 immediately. After release, src_ready=4'b1111 and rr_ptr=0.
- Single source: src 1 sends {tag=5, data=32'hDEADBEEF, rob=3} at cycle 0 → in cycle 2, wen0=1, wtag0=5, wdata0=DEADBEEF, wrob0=3, and wen1=0.
- All four valid in the same cycle with tags 10..13, rr_ptr=0:
  - First output cycle: port 0 carries tag 10, port 1 carries tag 11.
  - Next cycle: tags 12 and 13.
  - Afterwards rr_ptr=0.
- Streaming: src 0 valid every cycle with incrementing tags while src 3 is idle → src_ready[0] stays 1, one write per cycle on port 0, no dropped or duplicated tags.
- Rotation fairness: sources 0, 1 and 2 continuously valid → over 6 output cycles each source receives exactly 4 grants, and no source waits more than 1 cycle.
- Flush with slots 0 and 3 occupied:
  - Flush cycle: src_ready=0.
  - Following cycle: wen0=wen1=0, all slots empty, rr_ptr=0.
  - A new result offered after the flush is written 2 cycles after its handshake.
